move_sequence_packer: RTL and testbench

Collects move codes one per cycle from the solver/host side and packs them into the 200-bit, 50-slot move vector that `update_state` consumes. Publishes the batch with a one-cycle `new_moves_ready` pulse. Holds the vector stable until `update_state` reports `state_updated`. Filters illegal codes and, optionally, cancels adjacent inverse moves.

---
 rtl/rbot_moves_pkg.sv | 37 +++
 rtl/move_sequence_packer_if.sv | 26 ++
 rtl/move_code_check.sv | 29 ++
 rtl/move_sequence_packer.sv | 105 ++++++++++
 tb/tb_move_sequence_packer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rbot_moves_pkg.sv
// Shared move-code definitions for the packer, update_state and solver blocks.
// Slot geometry, packer state encoding and the inverse-move helper.
package rbot_moves_pkg;

  localparam int MAX_MOVES = 50;
  localparam int MOVE_W    = 4;
  localparam int VEC_W     = MAX_MOVES * MOVE_W;
  localparam int CNT_W     = 6;

  localparam logic [MOVE_W-1:0] MV_NULL = 4'd0;
  localparam logic [MOVE_W-1:0] MV_R    = 4'd2;
  localparam logic [MOVE_W-1:0] MV_RI   = 4'd3;
  localparam logic [MOVE_W-1:0] MV_U    = 4'd4;
  localparam logic [MOVE_W-1:0] MV_UI   = 4'd5;
  localparam logic [MOVE_W-1:0] MV_F    = 4'd6;
  localparam logic [MOVE_W-1:0] MV_FI   = 4'd7;
  localparam logic [MOVE_W-1:0] MV_L    = 4'd8;
  localparam logic [MOVE_W-1:0] MV_LI   = 4'd9;
  localparam logic [MOVE_W-1:0] MV_B    = 4'd10;
  localparam logic [MOVE_W-1:0] MV_BI   = 4'd11;
  localparam logic [MOVE_W-1:0] MV_D    = 4'd12;
  localparam logic [MOVE_W-1:0] MV_DI   = 4'd13;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PUBLISH,
    ST_WAIT
  } pack_state_t;

  // Each face turn and its inverse differ only in bit 0.
  function automatic logic [MOVE_W-1:0] inverse_move(
    input logic [MOVE_W-1:0] m
  );
    return {m[MOVE_W-1:1], ~m[0]};
  endfunction

endpackage

// File: rtl/move_sequence_packer_if.sv
// Handshake bundle between the move source / update_state and the packer.
// master = source and downstream side, slave = packer.
interface move_sequence_packer_if;
  import rbot_moves_pkg::*;

  logic [MOVE_W-1:0] move_in;
  logic              move_valid;
  logic              seq_done;
  logic              move_ready;
  logic              state_updated;
  logic [VEC_W-1:0]  moves;
  logic              new_moves_ready;
  logic [CNT_W-1:0]  batch_len;
  logic              bad_move;

  modport master (
    output move_in, move_valid, seq_done, state_updated,
    input  move_ready, moves, new_moves_ready, batch_len, bad_move
  );

  modport slave (
    input  move_in, move_valid, seq_done, state_updated,
    output move_ready, moves, new_moves_ready, batch_len, bad_move
  );

endinterface

// File: rtl/move_code_check.sv
// Classifies an offered move code; MOVE_CANCEL_EN enables
// inverse-of-last-stored detection (otherwise o_cancel stays 0).
module move_code_check
  import rbot_moves_pkg::*;
(
  input  logic [MOVE_W-1:0] i_move,
  input  logic [MOVE_W-1:0] i_last,
  input  logic              i_has_last,
  output logic              o_null,
  output logic              o_legal,
  output logic              o_illegal,
  output logic              o_cancel
);

`ifdef MOVE_CANCEL_EN
  localparam bit CancelEn = 1'b1;
`else
  localparam bit CancelEn = 1'b0;
`endif

  always_comb begin
    o_null    = (i_move == MV_NULL);
    o_legal   = (i_move >= MV_R) && (i_move <= MV_DI);
    o_illegal = !o_null && !o_legal;
    o_cancel  = CancelEn && o_legal && i_has_last
             && (inverse_move(i_move) == i_last);
  end

endmodule

// File: rtl/move_sequence_packer.sv
// Packs accepted move codes into the 50-slot vector for update_state.
// Build option: MOVE_CANCEL_EN (adjacent inverse moves cancel out).
module move_sequence_packer
  import rbot_moves_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  move_sequence_packer_if.slave bus
);

  pack_state_t       r_state;
  logic [VEC_W-1:0]  r_moves;
  logic [CNT_W-1:0]  r_count;
  logic              r_pulse;
  logic              r_bad;

  logic              w_ready;
  logic              w_acc;
  logic              w_store;
  logic              w_pop;
  logic              w_trig;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [MOVE_W-1:0] w_last;
  logic              w_null;
  logic              w_legal;
  logic              w_illegal;
  logic              w_cancel;

  always_comb begin
    w_last = '0;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (CNT_W'(i) == r_count - CNT_W'(1))
        w_last = r_moves[VEC_W-1-i*MOVE_W -: MOVE_W];
    end
  end

  move_code_check u_check (
    .i_move     (bus.move_in),
    .i_last     (w_last),
    .i_has_last (r_count != '0),
    .o_null     (w_null),
    .o_legal    (w_legal),
    .o_illegal  (w_illegal),
    .o_cancel   (w_cancel)
  );

  always_comb begin
    w_ready   = (r_state == ST_COLLECT)
             && (r_count < CNT_W'(MAX_MOVES));
    w_acc     = bus.move_valid && w_ready;
    w_store   = w_acc && w_legal && !w_cancel;
    w_pop     = w_acc && w_cancel;
    w_cnt_nxt = r_count + CNT_W'(w_store) - CNT_W'(w_pop);
    // Count after this cycle's accept decides the publish.
    w_trig    = (bus.seq_done && (w_cnt_nxt != '0))
             || (w_cnt_nxt == CNT_W'(MAX_MOVES));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_COLLECT;
      r_moves <= '0;
      r_count <= '0;
      r_pulse <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_COLLECT: begin
          if (w_acc && w_illegal)
            r_bad <= 1'b1;
          for (int i = 0; i < MAX_MOVES; i++) begin
            if (w_store && CNT_W'(i) == r_count)
              r_moves[VEC_W-1-i*MOVE_W -: MOVE_W] <= bus.move_in;
            if (w_pop && CNT_W'(i) == r_count - CNT_W'(1))
              r_moves[VEC_W-1-i*MOVE_W -: MOVE_W] <= MV_NULL;
          end
          r_count <= w_cnt_nxt;
          if (w_trig) begin
            r_pulse <= 1'b1;
            r_state <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          r_pulse <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.state_updated) begin
            r_moves <= '0;
            r_count <= '0;
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.move_ready      = w_ready;
  assign bus.moves           = r_moves;
  assign bus.new_moves_ready = r_pulse;
  assign bus.batch_len       = r_count;
  assign bus.bad_move        = r_bad;

endmodule

// File: tb/tb_move_sequence_packer.sv
// Directed bench for move_sequence_packer.
// Expectations follow the MOVE_CANCEL_EN setting of the build.
module tb_move_sequence_packer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  move_sequence_packer_if bus ();

  move_sequence_packer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [199:0] obs,
                     input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] code, input logic done);
    bus.move_in    = code;
    bus.move_valid = 1'b1;
    bus.seq_done   = done;
    step();
    bus.move_valid = 1'b0;
    bus.seq_done   = 1'b0;
  endtask

  task automatic release_batch();
    bus.state_updated = 1'b1;
    step();
    bus.state_updated = 1'b0;
  endtask

  initial begin
    logic [199:0] all_r;
    checks = 0;
    errors = 0;
    all_r  = '0;
    for (int i = 0; i < 50; i++) all_r[i*4 +: 4] = 4'h2;

    reset             = 1'b1;
    bus.move_in       = '0;
    bus.move_valid    = 1'b0;
    bus.seq_done      = 1'b0;
    bus.state_updated = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    chk("rst_moves", bus.moves, '0);
    chk("rst_pulse", bus.new_moves_ready, 0);
    chk("rst_len", bus.batch_len, 0);
    chk("rst_bad", bus.bad_move, 0);
    chk("rst_ready", bus.move_ready, 1);

    // R,U,F with seq_done on F
    send(4'd2, 1'b0);
    chk("ruf_partial", bus.moves[199:196], 4'h2);
    send(4'd4, 1'b0);
    send(4'd6, 1'b1);
    chk("ruf_pulse", bus.new_moves_ready, 1);
    chk("ruf_moves", bus.moves, {12'h246, 188'h0});
    chk("ruf_len", bus.batch_len, 3);
    chk("ruf_ready", bus.move_ready, 0);
    step();
    chk("ruf_pulse_end", bus.new_moves_ready, 0);
    chk("ruf_hold", bus.moves, {12'h246, 188'h0});
    bus.seq_done = 1'b1;
    step();
    bus.seq_done = 1'b0;
    chk("wait_seqdone_ign", bus.new_moves_ready, 0);
    release_batch();
    chk("ruf_clr_moves", bus.moves, '0);
    chk("ruf_clr_len", bus.batch_len, 0);
    chk("ruf_clr_ready", bus.move_ready, 1);

    // 55 R moves: auto-publish at 50, remainder next batch
    bus.move_in    = 4'd2;
    bus.move_valid = 1'b1;
    repeat (49) step();
    chk("ovf_len49", bus.batch_len, 49);
    chk("ovf_nopulse49", bus.new_moves_ready, 0);
    step();
    chk("ovf_pulse", bus.new_moves_ready, 1);
    chk("ovf_len", bus.batch_len, 50);
    chk("ovf_ready", bus.move_ready, 0);
    chk("ovf_moves", bus.moves, all_r);
    step();
    step();
    chk("ovf_held_len", bus.batch_len, 50);
    chk("ovf_held_ready", bus.move_ready, 0);
    release_batch();
    chk("ovf_rel_ready", bus.move_ready, 1);
    chk("ovf_rel_len", bus.batch_len, 0);
    repeat (5) step();
    bus.move_valid = 1'b0;
    chk("ovf_next_len", bus.batch_len, 5);
    chk("ovf_next_moves", bus.moves, {20'h22222, 180'h0});
    chk("ovf_next_nopulse", bus.new_moves_ready, 0);
    bus.seq_done = 1'b1;
    step();
    bus.seq_done = 1'b0;
    chk("ovf_done_pulse", bus.new_moves_ready, 1);
    chk("ovf_done_len", bus.batch_len, 5);
    step();
    release_batch();

    // illegal, NULL, then L with seq_done
    send(4'd15, 1'b0);
    chk("bad_flag", bus.bad_move, 1);
    chk("bad_len", bus.batch_len, 0);
    send(4'd0, 1'b0);
    chk("null_len", bus.batch_len, 0);
    chk("null_nopulse", bus.new_moves_ready, 0);
    send(4'd8, 1'b1);
    chk("l_pulse", bus.new_moves_ready, 1);
    chk("l_len", bus.batch_len, 1);
    chk("l_moves", bus.moves, {4'h8, 196'h0});
    chk("bad_sticky", bus.bad_move, 1);
    step();
    release_batch();

    // seq_done with an empty buffer
    bus.seq_done = 1'b1;
    step();
    bus.seq_done = 1'b0;
    chk("empty_nopulse", bus.new_moves_ready, 0);
    chk("empty_ready", bus.move_ready, 1);
    step();
    chk("empty_nopulse2", bus.new_moves_ready, 0);

    // R,Ri,U,Ri,R,D with seq_done on D
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b0);
    send(4'd3, 1'b0);
    send(4'd2, 1'b0);
    send(4'd12, 1'b1);
    chk("seq_pulse", bus.new_moves_ready, 1);
`ifdef MOVE_CANCEL_EN
    chk("seq_len", bus.batch_len, 2);
    chk("seq_moves", bus.moves, {8'h4C, 192'h0});
`else
    chk("seq_len", bus.batch_len, 6);
    chk("seq_moves", bus.moves, {24'h23432C, 176'h0});
`endif
    step();
    release_batch();

`ifdef MOVE_CANCEL_EN
    // chain cancelling to empty together with seq_done
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd3, 1'b0);
    send(4'd2, 1'b1);
    chk("chain_nopulse", bus.new_moves_ready, 0);
    chk("chain_len", bus.batch_len, 0);
    chk("chain_moves", bus.moves, '0);
    chk("chain_ready", bus.move_ready, 1);
`endif

    // reset while waiting on downstream
    send(4'd10, 1'b1);
    chk("rw_pulse", bus.new_moves_ready, 1);
    step();
    chk("rw_wait_ready", bus.move_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_moves", bus.moves, '0);
    chk("rw_ready", bus.move_ready, 1);
    chk("rw_pulse_low", bus.new_moves_ready, 0);
    chk("rw_len", bus.batch_len, 0);
    chk("rw_bad", bus.bad_move, 0);
    step();
    chk("rw_pulse_low2", bus.new_moves_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
